seg7_rx_decoder: RTL
====================

Name: seg7_rx_decoder

Overview:
Receive-side counterpart of the counter/7-segment driver. Samples a 7-bit segment bus and filters glitches by requiring a pattern to hold for a programmable number of cycles. Decodes accepted patterns back to a binary digit and checks that successive digits follow a modulo-MOD up-count. Used on-chip as a self-check monitor and as the loopback reader for display-driven counters.

Parameters:
STABLE_CYCLES, 3, consecutive identical samples required before a pattern is accepted (1..255)
MOD, 8, expected count modulus for sequence checking (2..10)
SEG_ACTIVE_LOW, 0, 1 = iSeg is active-low (common anode); inverted before decode
CNT_W, 8, width of error/accept counters (saturating)

Ports:
CLK  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
iSeg  in  7  segment bus {a,b,c,d,e,f,g}, bit6 = a
iClrErr  in  1  synchronous clear of oErrCnt and oSeqErr
oQ  out  4  last accepted digit value (0..9)
oValid  out  1  one-cycle pulse when a new digit is accepted
oLocked  out  1  high once two consecutive accepted digits are in sequence
oInvalid  out  1  one-cycle pulse when a stable but undecodable pattern is accepted
oSeqErr  out  1  sticky; set on sequence mismatch while locked
oErrCnt  out  CNT_W  saturating count of sequence errors plus invalid patterns

Behaviour:
- Reset (async assert, sync release): oQ=0, oValid=0, oLocked=0, oInvalid=0, oSeqErr=0, oErrCnt=0, stability counter=0, held pattern=7'h00, FSM=S_SYNC.
- Normalisation: seg = SEG_ACTIVE_LOW ? ~iSeg : iSeg. Input register stage: one cycle.
- Decode table (active-high abcdefg): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B. Blank 00 is ignored: never accepted, never an error. Any other code is invalid.
- Stability filter: if sampled seg == held pattern, stab_cnt increments (saturating at STABLE_CYCLES). Otherwise, held pattern = seg and stab_cnt = 1.
- Acceptance happens on the cycle stab_cnt reaches STABLE_CYCLES. Each held pattern is accepted at most once.
- Latency: iSeg change to oValid = STABLE_CYCLES + 1 cycles.
- On accept of a valid digit d:
  - oQ <= d, oValid pulses.
  - In S_LOCKED, if d != (prev+1) mod MOD: oSeqErr <= 1, oErrCnt += 1, FSM -> S_SYNC.
- On accept of an invalid pattern: oInvalid pulses, oErrCnt += 1, FSM -> S_SYNC. oQ holds its value.
- FSM:
  - S_SYNC: accepts the first valid digit, stores it as prev, -> S_CHECK.
  - S_CHECK: next valid digit == (prev+1) mod MOD -> S_LOCKED (oLocked=1). Otherwise stay in S_CHECK with prev = d. No error is raised in S_CHECK.
  - S_LOCKED: checks every valid accept as above. oLocked = (FSM == S_LOCKED).
- A digit >= MOD is a sequence error when in S_LOCKED.
- Wrap: MOD-1 -> 0 is in sequence.
- oErrCnt saturates at all-ones.
- iClrErr: clears oErrCnt and oSeqErr next edge. If it coincides with an error event, the clear takes priority. FSM is unaffected.
- Reset mid-pattern discards the partial stability count. After release, the first accept requires a full STABLE_CYCLES.

Decomposition:
- Package seg7_pkg: segment code localparams SEG_0..SEG_9 and SEG_BLANK; FSM state enum (S_SYNC, S_CHECK, S_LOCKED); function seg7_to_bin returning {valid, value[3:0]}. The existing encoder should reuse this package.
- One natural sub-module: seg7_stable_filter (input register, held pattern, stab_cnt, accept pulse).

Test Plan:
1. Drive patterns 0..7..0 (7E,30,6D,79,33,5B,5F,70,7E), each held 40 cycles, MOD=8 -> oValid pulses 4 cycles after each change; oLocked high after the second digit; oSeqErr=0; oErrCnt=0.
2. 2-cycle glitch of 7F between stable digits, STABLE_CYCLES=3 -> no oValid and no error for the glitch; the sequence stays locked.
3. While locked at 3, drive 5B (5) -> oQ=5, oSeqErr=1, oErrCnt=1, oLocked=0; then 6,7 -> relock.
4. Stable 0x55 -> oInvalid pulse, oErrCnt+1, oQ unchanged. Stable 0x00 -> no pulse of any kind.
5. SEG_ACTIVE_LOW=1, drive ~7E then ~30 -> oQ=0 then 1 and oLocked=1. Assert iClrErr together with an injected error -> oErrCnt=0.
6. Assert rst_n low for 7 ns mid-hold -> all outputs 0 immediately. After release, a full STABLE_CYCLES is needed before oValid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment codes (abcdefg, bit6 = a), FSM states
// and the segment-to-binary decode used by both the encoder and the receiver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } seg7_state_t;

  // Returns {valid, value}; blank and unknown codes both come back not valid.
  function automatic logic [4:0] seg7_to_bin(input logic [6:0] seg);
    case (seg)
      SEG_0:   return 5'h10;
      SEG_1:   return 5'h11;
      SEG_2:   return 5'h12;
      SEG_3:   return 5'h13;
      SEG_4:   return 5'h14;
      SEG_5:   return 5'h15;
      SEG_6:   return 5'h16;
      SEG_7:   return 5'h17;
      SEG_8:   return 5'h18;
      SEG_9:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Input register plus glitch filter: a pattern is accepted once, on the cycle
// it has been sampled STABLE_CYCLES times in a row.
module seg7_stable_filter #(
  parameter int STABLE_CYCLES  = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [6:0] iSeg,
  output logic [6:0] pat,
  output logic       accept
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [6:0] seg_q, seg_d;
  logic [6:0] held_q, held_d;
  logic [7:0] stab_q, stab_d;

  always_comb begin
    seg_d  = SEG_ACTIVE_LOW ? ~iSeg : iSeg;
    held_d = held_q;
    stab_d = stab_q;
    if (seg_q == held_q) begin
      if (stab_q != STAB_MAX) stab_d = stab_q + 8'd1;
    end else begin
      held_d = seg_q;
      stab_d = 8'd1;
    end
    // Fires only on the transition into the terminal count, so a held pattern
    // is reported exactly once however long it stays.
    accept = (stab_d == STAB_MAX) && ((stab_q != STAB_MAX) || (seg_q != held_q));
  end

  assign pat = held_d;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 7'h00;
      held_q <= 7'h00;
      stab_q <= 8'd0;
    end else begin
      seg_q  <= seg_d;
      held_q <= held_d;
      stab_q <= stab_d;
    end
  end

endmodule

// File: rtl/seg7_rx_decoder.sv
// Segment-bus receiver: filters, decodes and checks that accepted digits
// follow a modulo-MOD up-count.
//   state    | meaning
//   S_SYNC   | no reference digit yet
//   S_CHECK  | have one digit, waiting for an in-sequence successor
//   S_LOCKED | sequence confirmed, every new digit is checked
module seg7_rx_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 3,
  parameter int MOD            = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int CNT_W          = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic [6:0]       iSeg,
  input  logic             iClrErr,
  output logic [3:0]       oQ,
  output logic             oValid,
  output logic             oLocked,
  output logic             oInvalid,
  output logic             oSeqErr,
  output logic [CNT_W-1:0] oErrCnt
);

  localparam logic [3:0] MOD_V = 4'(MOD);

  logic [6:0]       acc_pat;
  logic             acc;
  logic [4:0]       dec;
  logic [3:0]       next_exp;
  logic             err_evt;

  logic [3:0]       q_q, q_d;
  logic [3:0]       prev_q, prev_d;
  logic             valid_q, valid_d;
  logic             invalid_q, invalid_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  seg7_state_t      state_q, state_d;

  seg7_stable_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_filt (
    .CLK   (CLK),
    .rst_n (rst_n),
    .iSeg  (iSeg),
    .pat   (acc_pat),
    .accept(acc)
  );

  always_comb begin
    dec      = seg7_to_bin(acc_pat);
    next_exp = prev_q + 4'd1;
    if (next_exp >= MOD_V) next_exp = next_exp - MOD_V;

    q_d       = q_q;
    prev_d    = prev_q;
    valid_d   = 1'b0;
    invalid_d = 1'b0;
    seq_err_d = seq_err_q;
    err_cnt_d = err_cnt_q;
    state_d   = state_q;
    err_evt   = 1'b0;

    if (acc && (acc_pat != SEG_BLANK)) begin
      if (dec[4]) begin
        q_d     = dec[3:0];
        prev_d  = dec[3:0];
        valid_d = 1'b1;
        case (state_q)
          S_SYNC:   state_d = S_CHECK;
          S_CHECK:  if (dec[3:0] == next_exp) state_d = S_LOCKED;
          S_LOCKED: begin
            if (dec[3:0] != next_exp) begin
              seq_err_d = 1'b1;
              err_evt   = 1'b1;
              state_d   = S_SYNC;
            end
          end
          default:  state_d = S_SYNC;
        endcase
      end else begin
        invalid_d = 1'b1;
        err_evt   = 1'b1;
        state_d   = S_SYNC;
      end
    end

    if (err_evt && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
    // Clear wins over a coincident error; the FSM still takes its transition.
    if (iClrErr) begin
      err_cnt_d = '0;
      seq_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= 4'd0;
      prev_q    <= 4'd0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
      state_q   <= S_SYNC;
    end else begin
      q_q       <= q_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
      state_q   <= state_d;
    end
  end

  assign oQ       = q_q;
  assign oValid   = valid_q;
  assign oInvalid = invalid_q;
  assign oSeqErr  = seq_err_q;
  assign oErrCnt  = err_cnt_q;
  assign oLocked  = (state_q == S_LOCKED);

endmodule
